// File: rtl/paddle_tracker.sv
// rtl/paddle_tracker.sv - round-robin paddle register reader with atomic per-channel triple commit
// Optional motion outputs dx/dy enabled by defining PADDLE_TRACKER_VELOCITY_EN.
module paddle_tracker #(
   parameter int NPAD     = 2,
   parameter int DATA_W   = 16,
   parameter int STATUS_W = 2,
   localparam int SEL_W   = (NPAD > 1) ? $clog2(NPAD) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NPAD-1:0]            dav,
   input  logic [DATA_W-1:0]          data,
   output logic [SEL_W-1:0]           sel,
   output logic [1:0]                 addr,
   output logic [NPAD*DATA_W-1:0]     x_loc,
   output logic [NPAD*DATA_W-1:0]     y_loc,
   output logic [NPAD*STATUS_W-1:0]   status,
   output logic [NPAD-1:0]            upd,
   output logic                       busy,
   output logic [NPAD*DATA_W-1:0]     dx,
   output logic [NPAD*DATA_W-1:0]     dy
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_RD_STATUS = 3'd1;
   localparam logic [2:0] S_RD_X      = 3'd2;
   localparam logic [2:0] S_RD_Y      = 3'd3;
   localparam logic [2:0] S_COMMIT    = 3'd4;

   logic [2:0]               state_q, state_d;
   logic [NPAD-1:0]          pending_q, pending_d, clr;
   logic [SEL_W-1:0]         last_q, last_d;
   logic [SEL_W-1:0]         grant_q, grant_d;
   logic [SEL_W-1:0]         rr_gnt;
   logic [STATUS_W-1:0]      sh_st_q, sh_st_d;
   logic [DATA_W-1:0]        sh_x_q, sh_x_d;
   logic [DATA_W-1:0]        sh_y_q, sh_y_d;
   logic [NPAD*DATA_W-1:0]   x_loc_q, x_loc_d;
   logic [NPAD*DATA_W-1:0]   y_loc_q, y_loc_d;
   logic [NPAD*STATUS_W-1:0] status_q, status_d;
   logic [NPAD-1:0]          upd_q, upd_d;
   int                       rr_idx;

   // Scan from farthest to nearest so the candidate right after last_q wins.
   always_comb begin
      rr_gnt = '0;
      rr_idx = 0;
      for (int i = NPAD; i >= 1; i--) begin
         rr_idx = (int'(last_q) + i) % NPAD;
         if (pending_q[rr_idx]) rr_gnt = SEL_W'(rr_idx);
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      sh_st_d  = sh_st_q;
      sh_x_d   = sh_x_q;
      sh_y_d   = sh_y_q;
      x_loc_d  = x_loc_q;
      y_loc_d  = y_loc_q;
      status_d = status_q;
      upd_d    = '0;
      clr      = '0;
      case (state_q)
         S_IDLE: begin
            if (|pending_q) begin
               grant_d = rr_gnt;
               state_d = S_RD_STATUS;
            end
         end
         S_RD_STATUS: begin
            sh_st_d = data[STATUS_W-1:0];
            state_d = S_RD_X;
         end
         S_RD_X: begin
            sh_x_d  = data;
            state_d = S_RD_Y;
         end
         S_RD_Y: begin
            sh_y_d         = data;
            clr[grant_q]   = 1'b1;
            state_d        = S_COMMIT;
         end
         S_COMMIT: begin
            x_loc_d[int'(grant_q)*DATA_W +: DATA_W]     = sh_x_q;
            y_loc_d[int'(grant_q)*DATA_W +: DATA_W]     = sh_y_q;
            status_d[int'(grant_q)*STATUS_W +: STATUS_W] = sh_st_q;
            upd_d[grant_q] = 1'b1;
            last_d         = grant_q;
            state_d        = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A dav seen on the clearing edge keeps the request alive.
   assign pending_d = (pending_q & ~clr) | dav;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pending_q <= '0;
         last_q    <= SEL_W'(NPAD - 1);
         grant_q   <= '0;
         sh_st_q   <= '0;
         sh_x_q    <= '0;
         sh_y_q    <= '0;
         x_loc_q   <= '0;
         y_loc_q   <= '0;
         status_q  <= '0;
         upd_q     <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         last_q    <= last_d;
         grant_q   <= grant_d;
         sh_st_q   <= sh_st_d;
         sh_x_q    <= sh_x_d;
         sh_y_q    <= sh_y_d;
         x_loc_q   <= x_loc_d;
         y_loc_q   <= y_loc_d;
         status_q  <= status_d;
         upd_q     <= upd_d;
      end
   end

`ifdef PADDLE_TRACKER_VELOCITY_EN
   logic [NPAD*DATA_W-1:0] dx_q, dx_d, dy_q, dy_d;

   always_comb begin
      dx_d = dx_q;
      dy_d = dy_q;
      if (state_q == S_COMMIT) begin
         dx_d[int'(grant_q)*DATA_W +: DATA_W] = sh_x_q - x_loc_q[int'(grant_q)*DATA_W +: DATA_W];
         dy_d[int'(grant_q)*DATA_W +: DATA_W] = sh_y_q - y_loc_q[int'(grant_q)*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dx_q <= '0;
         dy_q <= '0;
      end else begin
         dx_q <= dx_d;
         dy_q <= dy_d;
      end
   end

   assign dx = dx_q;
   assign dy = dy_q;
`else
   assign dx = '0;
   assign dy = '0;
`endif

   always_comb begin
      addr = 2'd0;
      case (state_q)
         S_RD_X:  addr = 2'd1;
         S_RD_Y:  addr = 2'd2;
         default: addr = 2'd0;
      endcase
   end

   assign sel    = (state_q == S_IDLE) ? '0 : grant_q;
   assign busy   = (state_q != S_IDLE);
   assign x_loc  = x_loc_q;
   assign y_loc  = y_loc_q;
   assign status = status_q;
   assign upd    = upd_q;

endmodule

// File: doc/paddle_tracker.md
PADDLE_TRACKER -- requirements
Module: paddle_tracker

Interface
REQ-001 SHALL provide parameter NPAD, default 2: number of paddle channels, legal range 1..8.
REQ-002 SHALL provide parameter DATA_W, default 16: width of the data word and of each x/y location.
REQ-003 SHALL provide parameter STATUS_W, default 2: width of each status field, 1..DATA_W, taken from data[STATUS_W-1:0].
REQ-004 SHALL use one clock; reset is asynchronous and active-high; ports are clk and rst.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 dav  input  NPAD  per-channel data-available level from the receiver register file.
REQ-008 data  input  DATA_W  read data for the register currently selected by sel/addr, valid in the same cycle.
REQ-009 sel  output  max(1,clog2(NPAD))  channel select to the register file, combinational from state.
REQ-010 addr  output  2  register select: 0=status, 1=x, 2=y; combinational from state.
REQ-011 x_loc, y_loc  output  NPAD*DATA_W  packed per-channel locations; channel k at bits [k*DATA_W +: DATA_W].
REQ-012 status  output  NPAD*STATUS_W  packed per-channel status, same packing rule.
REQ-013 upd  output  NPAD  one-cycle pulse on channel k when its new triple becomes visible.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 dx, dy  output  NPAD*DATA_W  signed per-channel motion since previous update (see Configuration).

Function
REQ-016 SHALL keep pending[NPAD]; pending[k] set on any clk edge where dav[k]=1; cleared at the RD_Y edge servicing k unless dav[k]=1 that cycle (set wins).
REQ-017 SHALL implement states IDLE, RD_STATUS, RD_X, RD_Y, COMMIT; IDLE drives sel=0, addr=0.
REQ-018 IDLE: if any pending bit set, grant channel g chosen round-robin starting at (last_served+1) mod NPAD; next state RD_STATUS; else remain.
REQ-019 RD_STATUS: sel=g, addr=0, capture data[STATUS_W-1:0] into shadow; next RD_X.
REQ-020 RD_X: sel=g, addr=1, capture data into shadow x; next RD_Y.
REQ-021 RD_Y: sel=g, addr=2, capture data into shadow y; next COMMIT.
REQ-022 COMMIT: at its closing edge, status/x_loc/y_loc of channel g load from shadows simultaneously, upd[g]=1 for exactly the following cycle, last_served=g; next IDLE.
REQ-023 Outputs of channel k SHALL change only at a COMMIT edge for k; partial triples are never visible.
REQ-024 Minimum service latency: dav[k] sampled at edge 0 -> upd[k] high after edge 5 (pending, grant, 3 reads, commit).
REQ-025 Two channels pending simultaneously after reset SHALL be served channel 0 first, then channel 1, back-to-back with one IDLE cycle between.
REQ-026 dav held high continuously SHALL re-service the channel repeatedly, alternating fairly with other pending channels.
REQ-027 No arithmetic overflow handling on locations: stored values are raw data words.

Reset
REQ-028 While rst=1 SHALL force state=IDLE, pending=0, last_served=NPAD-1, all shadows, x_loc, y_loc, status, dx, dy, upd to 0; busy=0.
REQ-029 Reset asserted mid-sequence SHALL discard the in-flight triple; outputs hold reset values, no upd pulse.

Configuration
REQ-030 Macro PADDLE_TRACKER_VELOCITY_EN defined: at each COMMIT for g, dx[g]=new_x-old x_loc[g], dy[g]=new_y-old y_loc[g], DATA_W-bit two's-complement wrap, updated on the same edge as x_loc.
REQ-031 Macro undefined: dx and dy SHALL remain present and constant 0; no subtractors synthesised.

Verification
REQ-032 NPAD=2; dav[0] pulse 1 cycle, data returns status=0x0002, x=0x0123, y=0x0456 -> x_loc[0]=0x0123, y_loc[0]=0x0456, status[0]=2, upd[0] one cycle, 5 edges after dav.
REQ-033 dav=2'b11 same cycle -> channel 0 served then channel 1; upd[0] then upd[1] 5 cycles apart; sel sequence 0,0,0 then 1,1,1.
REQ-034 rst pulsed during RD_X of channel 1 with x=0x00FF -> x_loc[1] stays 0, no upd, state IDLE, pending cleared.
REQ-035 dav[1] high continuously, dav[0] pulsed once mid-service -> channel 0 served next, then channel 1 resumes.
REQ-036 VELOCITY_EN: x 0x0010 then 0x0008 -> dx[0]=0xFFF8; without macro dx[0]=0.
REQ-037 Random 10k-cycle dav/data run vs reference model -> every upd matches model triple, no torn update observed.
